// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the RV32I ALU issue/decode stage.
// Opcodes, ALU codes, operand selects and the decoded bundle.
package alu_issue_pkg;

  localparam int XLEN_P = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    LHS_RS1  = 2'd0,
    LHS_PC   = 2'd1,
    LHS_ZERO = 2'd2
  } lhs_sel_e;

  typedef enum logic [1:0] {
    RHS_RS2  = 2'd0,
    RHS_IMM  = 2'd1,
    RHS_FOUR = 2'd2
  } rhs_sel_e;

  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LTU = 3'd2;
  localparam logic [2:0] CMP_LT  = 3'd3;
  localparam logic [2:0] CMP_GEU = 3'd4;
  localparam logic [2:0] CMP_GE  = 3'd5;

  typedef struct packed {
    logic [3:0]        fn;
    lhs_sel_e          lhs;
    rhs_sel_e          rhs;
    logic [XLEN_P-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              reg_write;
    logic              is_branch;
    logic              is_jump;
    logic              is_load;
    logic              is_store;
    logic [2:0]        bcond;
    logic              illegal;
    logic [XLEN_P-1:0] pc;
  } dec_t;

endpackage

// File: rtl/rv32i_alu_decode.sv
// Combinational RV32I instruction to ALU issue bundle decoder.
// Illegal encodings collapse to a harmless bundle flagged illegal.
module rv32i_alu_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]       instr_i,
  input  logic [XLEN_P-1:0] pc_i,
  output dec_t              dec_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;
  dec_t       d;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  logic [XLEN_P-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25],
                  instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                  instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31],
                  instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  always_comb begin
    d     = '0;
    ill   = 1'b0;
    d.rs1 = instr_i[19:15];
    d.rs2 = instr_i[24:20];
    d.rd  = instr_i[11:7];
    d.pc  = pc_i;
    unique case (1'b1)
      (instr_i[1:0] != 2'b11): ill = 1'b1;
      (opc == OPC_OP): begin
        d.fn        = {instr_i[30], f3};
        d.reg_write = 1'b1;
        ill = !((f7 == 7'b0000000) ||
                (f7 == 7'b0100000 &&
                 (f3 == 3'b000 || f3 == 3'b101)));
      end
      (opc == OPC_OP_IMM): begin
        d.fn        = {(f3 == 3'b101) & instr_i[30], f3};
        d.rhs       = RHS_IMM;
        d.imm       = imm_i;
        d.reg_write = 1'b1;
        if (f3 == 3'b001)
          ill = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      (opc == OPC_LUI): begin
        d.lhs       = LHS_ZERO;
        d.rhs       = RHS_IMM;
        d.imm       = imm_u;
        d.reg_write = 1'b1;
      end
      (opc == OPC_AUIPC): begin
        d.lhs       = LHS_PC;
        d.rhs       = RHS_IMM;
        d.imm       = imm_u;
        d.reg_write = 1'b1;
      end
      (opc == OPC_JAL), (opc == OPC_JALR): begin
        d.lhs       = LHS_PC;
        d.rhs       = RHS_FOUR;
        d.imm       = (opc == OPC_JAL) ? imm_j : imm_i;
        d.is_jump   = 1'b1;
        d.reg_write = 1'b1;
        ill = (opc == OPC_JALR) && (f3 != 3'b000);
      end
      (opc == OPC_BRANCH): begin
        d.imm       = imm_b;
        d.is_branch = 1'b1;
        unique case (f3)
          3'b000:  d.bcond = CMP_EQ;
          3'b001:  d.bcond = CMP_NE;
          3'b100:  d.bcond = CMP_LT;
          3'b101:  d.bcond = CMP_GE;
          3'b110:  d.bcond = CMP_LTU;
          3'b111:  d.bcond = CMP_GEU;
          default: ill = 1'b1;
        endcase
      end
      (opc == OPC_LOAD): begin
        d.rhs       = RHS_IMM;
        d.imm       = imm_i;
        d.is_load   = 1'b1;
        d.reg_write = 1'b1;
        ill = (f3 == 3'b011) || (f3 == 3'b110) ||
              (f3 == 3'b111);
      end
      (opc == OPC_STORE): begin
        d.rhs      = RHS_IMM;
        d.imm      = imm_s;
        d.is_store = 1'b1;
        ill = (f3 > 3'b010);
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      d.fn        = ALU_ADD;
      d.lhs       = LHS_RS1;
      d.rhs       = RHS_RS2;
      d.imm       = '0;
      d.reg_write = 1'b0;
      d.is_branch = 1'b0;
      d.is_jump   = 1'b0;
      d.is_load   = 1'b0;
      d.is_store  = 1'b0;
      d.bcond     = 3'd0;
    end
    d.illegal   = ill;
    d.reg_write = d.reg_write && (d.rd != 5'd0);
  end

  assign dec_o = d;

endmodule

// File: rtl/alu_issue_decoder.sv
// Decode/issue stage: output register plus one-entry skid buffer
// so that In_Ready comes straight from a flop.
module alu_issue_decoder
  import alu_issue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [31:0]     In_Instruction,
  input  logic [XLEN-1:0] In_PC,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [3:0]      Out_Function,
  output logic [1:0]      Out_LHSSelect,
  output logic [1:0]      Out_RHSSelect,
  output logic [XLEN-1:0] Out_Immediate,
  output logic [4:0]      Out_Rs1,
  output logic [4:0]      Out_Rs2,
  output logic [4:0]      Out_Rd,
  output logic            Out_RegWrite,
  output logic            Out_IsBranch,
  output logic            Out_IsJump,
  output logic            Out_IsLoad,
  output logic            Out_IsStore,
  output logic [2:0]      Out_BranchCond,
  output logic            Out_Illegal,
  output logic [XLEN-1:0] Out_PC
);

  dec_t dec;
  dec_t out_q, out_d;
  dec_t sk_q, sk_d;
  logic ov_q, ov_d;
  logic sv_q, sv_d;
  logic rdy_q, rdy_d;
  logic acc;

  rv32i_alu_decode u_dec (
    .instr_i (In_Instruction),
    .pc_i    (In_PC),
    .dec_o   (dec)
  );

  // rdy_q also masks In_Ready until the first edge after reset
  assign In_Ready = SKID_EN ? rdy_q
                            : (rdy_q && (Out_Ready || !ov_q));
  assign acc = In_Valid && In_Ready;

  always_comb begin
    out_d = out_q;
    ov_d  = ov_q;
    sk_d  = sk_q;
    sv_d  = sv_q;
    if (!ov_q || Out_Ready) begin
      if (sv_q) begin
        out_d = sk_q;
        ov_d  = 1'b1;
        if (acc) sk_d = dec;
        else     sv_d = 1'b0;
      end else if (acc) begin
        out_d = dec;
        ov_d  = 1'b1;
      end else begin
        ov_d  = 1'b0;
      end
    end else if (acc && SKID_EN) begin
      sk_d = dec;
      sv_d = 1'b1;
    end
    rdy_d = !sv_d;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      out_q <= '0;
      ov_q  <= 1'b0;
      sk_q  <= '0;
      sv_q  <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ov_q  <= ov_d;
      sk_q  <= sk_d;
      sv_q  <= sv_d;
      rdy_q <= rdy_d;
    end
  end

  assign Out_Valid      = ov_q;
  assign Out_Function   = out_q.fn;
  assign Out_LHSSelect  = out_q.lhs;
  assign Out_RHSSelect  = out_q.rhs;
  assign Out_Immediate  = out_q.imm;
  assign Out_Rs1        = out_q.rs1;
  assign Out_Rs2        = out_q.rs2;
  assign Out_Rd         = out_q.rd;
  assign Out_RegWrite   = out_q.reg_write;
  assign Out_IsBranch   = out_q.is_branch;
  assign Out_IsJump     = out_q.is_jump;
  assign Out_IsLoad     = out_q.is_load;
  assign Out_IsStore    = out_q.is_store;
  assign Out_BranchCond = out_q.bcond;
  assign Out_Illegal    = out_q.illegal;
  assign Out_PC         = out_q.pc;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed bench for alu_issue_decoder: decode table,
// backpressure stream and mid-cycle reset.
module tb_alu_issue_decoder;

  logic        Clock, Reset_n;
  logic        In_Valid, In_Ready;
  logic [31:0] In_Instruction, In_PC;
  logic        Out_Valid, Out_Ready;
  logic [3:0]  Out_Function;
  logic [1:0]  Out_LHSSelect, Out_RHSSelect;
  logic [31:0] Out_Immediate, Out_PC;
  logic [4:0]  Out_Rs1, Out_Rs2, Out_Rd;
  logic        Out_RegWrite, Out_IsBranch, Out_IsJump;
  logic        Out_IsLoad, Out_IsStore, Out_Illegal;
  logic [2:0]  Out_BranchCond;

  int nchk = 0;
  int nerr = 0;

  alu_issue_decoder dut (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .In_Valid       (In_Valid),
    .In_Ready       (In_Ready),
    .In_Instruction (In_Instruction),
    .In_PC          (In_PC),
    .Out_Valid      (Out_Valid),
    .Out_Ready      (Out_Ready),
    .Out_Function   (Out_Function),
    .Out_LHSSelect  (Out_LHSSelect),
    .Out_RHSSelect  (Out_RHSSelect),
    .Out_Immediate  (Out_Immediate),
    .Out_Rs1        (Out_Rs1),
    .Out_Rs2        (Out_Rs2),
    .Out_Rd         (Out_Rd),
    .Out_RegWrite   (Out_RegWrite),
    .Out_IsBranch   (Out_IsBranch),
    .Out_IsJump     (Out_IsJump),
    .Out_IsLoad     (Out_IsLoad),
    .Out_IsStore    (Out_IsStore),
    .Out_BranchCond (Out_BranchCond),
    .Out_Illegal    (Out_Illegal),
    .Out_PC         (Out_PC)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  fn;
    logic [1:0]  l;
    logic [1:0]  r;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        jp;
    logic        ld;
    logic        st;
    logic [2:0]  bc;
    logic        ill;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_vec(input int i, input logic [31:0] pc);
    string p;
    p = $sformatf("v%0d ", i);
    chk({p, "valid"}, 32'(Out_Valid), 32'd1);
    chk({p, "func"}, 32'(Out_Function), 32'(vt[i].fn));
    chk({p, "lhs"}, 32'(Out_LHSSelect), 32'(vt[i].l));
    chk({p, "rhs"}, 32'(Out_RHSSelect), 32'(vt[i].r));
    chk({p, "imm"}, Out_Immediate, vt[i].imm);
    chk({p, "rs1"}, 32'(Out_Rs1), 32'(vt[i].rs1));
    chk({p, "rs2"}, 32'(Out_Rs2), 32'(vt[i].rs2));
    chk({p, "rd"}, 32'(Out_Rd), 32'(vt[i].rd));
    chk({p, "regwrite"}, 32'(Out_RegWrite), 32'(vt[i].rw));
    chk({p, "isbranch"}, 32'(Out_IsBranch), 32'(vt[i].br));
    chk({p, "isjump"}, 32'(Out_IsJump), 32'(vt[i].jp));
    chk({p, "isload"}, 32'(Out_IsLoad), 32'(vt[i].ld));
    chk({p, "isstore"}, 32'(Out_IsStore), 32'(vt[i].st));
    chk({p, "bcond"}, 32'(Out_BranchCond), 32'(vt[i].bc));
    chk({p, "illegal"}, 32'(Out_Illegal), 32'(vt[i].ill));
    chk({p, "pc"}, Out_PC, pc);
  endtask

  logic [31:0] s_ins[4];
  logic [31:0] s_pc[4];
  logic [3:0]  s_fn[4];

  initial begin
    //           ins           fn    l     r     imm           rs1    rs2    rd     rw    br    jp    ld    st    bc    ill
    vt[0]  = '{32'h402081B3, 4'h8, 2'd0, 2'd0, 32'h00000000, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[1]  = '{32'h40335293, 4'hD, 2'd0, 2'd1, 32'h00000403, 5'd6,  5'd3,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[2]  = '{32'h42335293, 4'h0, 2'd0, 2'd0, 32'h00000000, 5'd6,  5'd3,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
    vt[3]  = '{32'h0020E463, 4'h0, 2'd0, 2'd0, 32'h00000008, 5'd1,  5'd2,  5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0};
    vt[4]  = '{32'h123453B7, 4'h0, 2'd2, 2'd1, 32'h12345000, 5'd8,  5'd3,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[5]  = '{32'hFFFFFFFF, 4'h0, 2'd0, 2'd0, 32'h00000000, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
    vt[6]  = '{32'h010000EF, 4'h0, 2'd1, 2'd2, 32'h00000010, 5'd0,  5'd16, 5'd1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[7]  = '{32'h00000033, 4'h0, 2'd0, 2'd0, 32'h00000000, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[8]  = '{32'h0020A623, 4'h0, 2'd0, 2'd1, 32'h0000000C, 5'd1,  5'd2,  5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
    vt[9]  = '{32'hFFC0A283, 4'h0, 2'd0, 2'd1, 32'hFFFFFFFC, 5'd1,  5'd28, 5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
    vt[10] = '{32'h00001217, 4'h0, 2'd1, 2'd1, 32'h00001000, 5'd0,  5'd0,  5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[11] = '{32'h00002063, 4'h0, 2'd0, 2'd0, 32'h00000000, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
    vt[12] = '{32'h4020D1B3, 4'hD, 2'd0, 2'd0, 32'h00000000, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[13] = '{32'hFFF12093, 4'h2, 2'd0, 2'd1, 32'hFFFFFFFF, 5'd2,  5'd31, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vt[14] = '{32'h402081B0, 4'h0, 2'd0, 2'd0, 32'h00000000, 5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};

    s_ins = '{32'h402081B3, 32'h40335293, 32'h0020E463, 32'h123453B7};
    s_pc  = '{32'h100, 32'h104, 32'h108, 32'h10C};
    s_fn  = '{4'h8, 4'hD, 4'h0, 4'h0};

    Reset_n = 1'b0;
    In_Valid = 1'b0;
    In_Instruction = '0;
    In_PC = '0;
    Out_Ready = 1'b0;
    #2;
    chk("reset in_ready", 32'(In_Ready), 32'd0);
    chk("reset out_valid", 32'(Out_Valid), 32'd0);
    chk("reset pc", Out_PC, 32'd0);
    chk("reset func", 32'(Out_Function), 32'd0);
    #10 Reset_n = 1'b1;
    tick();
    chk("post-reset in_ready", 32'(In_Ready), 32'd1);
    chk("post-reset out_valid", 32'(Out_Valid), 32'd0);

    // decode table, one instruction per cycle, no stalls
    Out_Ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      In_Valid = 1'b1;
      In_Instruction = vt[i].ins;
      In_PC = 32'h1000 + 32'(i * 4);
      tick();
      chk_vec(i, 32'h1000 + 32'(i * 4));
    end
    In_Valid = 1'b0;
    tick();
    chk("drain out_valid", 32'(Out_Valid), 32'd0);

    // backpressure stream with in-order scoreboard
    begin
      int sent, got;
      bit prev_stall;
      logic [31:0] h_pc, h_imm;
      logic [3:0] h_fn;
      bit fin;
      sent = 0;
      got = 0;
      prev_stall = 0;
      h_pc = '0;
      h_imm = '0;
      h_fn = '0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        In_Valid = (sent < 4);
        In_Instruction = s_ins[sent % 4];
        In_PC = s_pc[sent % 4];
        Out_Ready = (cyc >= 4);
        if (cyc == 2) begin
          chk("bp in_ready low", 32'(In_Ready), 32'd0);
          chk("bp accepted before stall", 32'(sent), 32'd2);
        end
        if (Out_Valid && !Out_Ready) begin
          if (prev_stall) begin
            chk("bp stable pc", Out_PC, h_pc);
            chk("bp stable imm", Out_Immediate, h_imm);
            chk("bp stable func", 32'(Out_Function), 32'(h_fn));
          end
          prev_stall = 1;
          h_pc = Out_PC;
          h_imm = Out_Immediate;
          h_fn = Out_Function;
        end else begin
          prev_stall = 0;
        end
        fin = In_Valid && In_Ready;
        if (Out_Valid && Out_Ready) begin
          chk($sformatf("bp out%0d pc", got), Out_PC, s_pc[got]);
          chk($sformatf("bp out%0d func", got),
              32'(Out_Function), 32'(s_fn[got]));
          got++;
        end
        tick();
        if (fin) sent++;
      end
      chk("bp outputs seen", 32'(got), 32'd4);
      In_Valid = 1'b0;
      Out_Ready = 1'b1;
      if (Out_Valid) begin
        nchk++;
        nerr++;
        $display("FAIL bp duplicate: got valid 1 expected 0");
        tick();
      end
      tick();
      chk("bp no extra", 32'(Out_Valid), 32'd0);
    end

    // fill output and skid, then reset mid-cycle
    Out_Ready = 1'b0;
    In_Valid = 1'b1;
    In_Instruction = s_ins[0];
    In_PC = 32'h200;
    tick();
    In_PC = 32'h204;
    tick();
    In_Valid = 1'b0;
    chk("pre-reset valid", 32'(Out_Valid), 32'd1);
    chk("pre-reset skid full", 32'(In_Ready), 32'd0);
    #3 Reset_n = 1'b0;
    #1;
    chk("mid reset out_valid", 32'(Out_Valid), 32'd0);
    chk("mid reset in_ready", 32'(In_Ready), 32'd0);
    chk("mid reset pc", Out_PC, 32'd0);
    #2 Reset_n = 1'b1;
    tick();
    chk("rerelease in_ready", 32'(In_Ready), 32'd1);
    chk("rerelease out_valid", 32'(Out_Valid), 32'd0);
    Out_Ready = 1'b1;
    In_Valid = 1'b1;
    In_Instruction = s_ins[3];
    In_PC = 32'h300;
    tick();
    In_Valid = 1'b0;
    chk("after reset first valid", 32'(Out_Valid), 32'd1);
    chk("after reset first pc", Out_PC, 32'h300);
    chk("after reset first rd", 32'(Out_Rd), 32'd7);
    tick();
    chk("after reset no stale", 32'(Out_Valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
